// File: rtl/volt_ctrl_pkg.sv
// Shared constants, state encoding and frame-word builder for the DAC SPI sequencer.
package volt_ctrl_pkg;

  localparam logic [2:0] DAC_CMD_WRITE  = 3'b110;
  localparam int         DAC_FRAME_BITS = 24;
  localparam int         DAC_CH_W       = 5;
  localparam int         DAC_CODE_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    LDAC
  } dac_state_e;

  function automatic logic [DAC_FRAME_BITS-1:0] dac_frame_word(
    input logic [DAC_CH_W-1:0]   ch,
    input logic [DAC_CODE_W-1:0] code
  );
    return {DAC_CMD_WRITE, ch, code};
  endfunction

endpackage

// File: rtl/dac_halfper_tick.sv
// Loadable down-counter marking the last cycle of an SCLK half-period or frame phase.
module dac_halfper_tick #(
  parameter int W = 2
) (
  input  logic         clk_clk,
  input  logic         reset_reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick,
  output logic         pre_tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // tick: current cycle ends the phase; pre_tick: next cycle does
  assign tick     = (cnt == '0);
  assign pre_tick = (cnt == W'(1));

endmodule

// File: rtl/dac_frame_sequencer.sv
// Serialises (channel, code) writes into 24-bit SPI frames and issues an optional LDAC_n strobe.
module dac_frame_sequencer
  import volt_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int LDAC_PULSE = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DAC_CH_W-1:0]   wr_ch,
  input  logic [DAC_CODE_W-1:0] wr_code,
  input  logic                  wr_last,
  output logic                  dac_sclk,
  output logic                  dac_sync_n,
  output logic                  dac_sdi,
  output logic                  dac_ldac_n,
  output logic                  frame_done
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int LP_W  = $clog2(LDAC_PULSE + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [LP_W-1:0]  LDAC_LOAD = LP_W'(LDAC_PULSE - 1);
  localparam logic [4:0]       BIT_TOP   = 5'(DAC_FRAME_BITS - 1);

  dac_state_e                state, state_nxt;
  logic                      phase_hi, phase_nxt;
  logic [4:0]                bit_cnt, bit_nxt;
  logic                      last_q, last_nxt;
  logic [LP_W-1:0]           ldac_cnt, ldac_cnt_nxt;
  logic [DAC_FRAME_BITS-1:0] shreg, shreg_nxt;
  logic                      ready_nxt, sclk_nxt, sync_nxt, sdi_nxt, ldac_nxt, done_nxt;
  logic                      div_load, tick, pre_tick;

  dac_halfper_tick #(.W(DIV_W)) u_tick (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .load          (div_load),
    .load_val      (DIV_LOAD),
    .tick          (tick),
    .pre_tick      (pre_tick)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      phase_hi   <= 1'b0;
      bit_cnt    <= '0;
      last_q     <= 1'b0;
      ldac_cnt   <= '0;
      wr_ready   <= 1'b0;
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_sdi    <= 1'b0;
      dac_ldac_n <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase_hi   <= phase_nxt;
      bit_cnt    <= bit_nxt;
      last_q     <= last_nxt;
      ldac_cnt   <= ldac_cnt_nxt;
      wr_ready   <= ready_nxt;
      dac_sclk   <= sclk_nxt;
      dac_sync_n <= sync_nxt;
      dac_sdi    <= sdi_nxt;
      dac_ldac_n <= ldac_nxt;
      frame_done <= done_nxt;
    end
  end

  // Frame data carries no reset; it is always loaded before being shifted out
  always_ff @(posedge clk_clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase_hi;
    bit_nxt      = bit_cnt;
    last_nxt     = last_q;
    ldac_cnt_nxt = ldac_cnt;
    shreg_nxt    = shreg;
    div_load     = 1'b0;
    ready_nxt    = 1'b0;
    sclk_nxt     = dac_sclk;
    sync_nxt     = dac_sync_n;
    sdi_nxt      = dac_sdi;
    ldac_nxt     = 1'b1;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        sclk_nxt  = 1'b1;
        sync_nxt  = 1'b1;
        sdi_nxt   = 1'b0;
        if (wr_valid && wr_ready) begin
          state_nxt = SETUP;
          div_load  = 1'b1;
          ready_nxt = 1'b0;
          sync_nxt  = 1'b0;
          shreg_nxt = dac_frame_word(wr_ch, wr_code);
          sdi_nxt   = shreg_nxt[DAC_FRAME_BITS-1];
          last_nxt  = wr_last;
          bit_nxt   = BIT_TOP;
          phase_nxt = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_nxt = SHIFT;
          div_load  = 1'b1;
          sclk_nxt  = 1'b0;
          phase_nxt = 1'b0;
        end
      end
      SHIFT: begin
        // sdi moves on the rising sclk so it is stable across the DAC's falling-edge sample
        if (tick) begin
          div_load = 1'b1;
          if (!phase_hi) begin
            sclk_nxt  = 1'b1;
            phase_nxt = 1'b1;
            if (bit_cnt != '0) begin
              shreg_nxt = shreg << 1;
              sdi_nxt   = shreg_nxt[DAC_FRAME_BITS-1];
            end
          end else if (bit_cnt == '0) begin
            state_nxt = HOLD;
          end else begin
            sclk_nxt  = 1'b0;
            phase_nxt = 1'b0;
            bit_nxt   = bit_cnt - 5'd1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_nxt = GAP;
          div_load  = 1'b1;
          sync_nxt  = 1'b1;
          sdi_nxt   = 1'b0;
        end
      end
      GAP: begin
        done_nxt = pre_tick;
        if (tick) begin
          if (last_q) begin
            state_nxt    = LDAC;
            ldac_nxt     = 1'b0;
            ldac_cnt_nxt = LDAC_LOAD;
          end else begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
          end
        end
      end
      LDAC: begin
        ldac_nxt = 1'b0;
        if (ldac_cnt == '0) begin
          state_nxt = IDLE;
          ldac_nxt  = 1'b1;
          ready_nxt = 1'b1;
        end else begin
          ldac_cnt_nxt = ldac_cnt - LP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
